// File: rtl/cp0_regs.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Handles exception/ERET bookkeeping and the fetch redirect request.
module cp0_regs #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Ext_Int_i,
  input  logic [4:0]  CP0_RdAddr_i,
  output logic [31:0] CP0_RdData_o,
  input  logic        CP0_WrEn_i,
  input  logic [4:0]  CP0_WrAddr_i,
  input  logic [31:0] CP0_WrData_i,
  input  logic        Exc_Valid_i,
  input  logic [4:0]  Exc_Code_i,
  input  logic        Exc_Eret_i,
  input  logic        Exc_IsDelaySlot_i,
  input  logic [31:0] Exc_PC_i,
  input  logic [31:0] Exc_BadVAddr_i,
  output logic [31:0] Status_o,
  output logic [31:0] Cause_o,
  output logic [31:0] EPC_o,
  output logic        Timer_Int_o,
  output logic        Redirect_o,
  output logic [31:0] Redirect_PC_o
);

  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_epc;
  logic        r_toggle;
  logic        r_ti;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ext;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;

  logic        w_flush;
  logic        w_wr;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // An MTC0 colliding with an exception/ERET is from the flushed window.
  assign w_flush      = Exc_Valid_i | Exc_Eret_i;
  assign w_wr         = CP0_WrEn_i & ~w_flush;
  assign w_wr_count   = w_wr & (CP0_WrAddr_i == 5'd9);
  assign w_wr_compare = w_wr & (CP0_WrAddr_i == 5'd11);

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, r_ext[5] | r_ti, r_ext[4:0],
                     r_ip_sw, 1'b0, r_exccode, 2'b0};

  assign Status_o    = w_status;
  assign Cause_o     = w_cause;
  assign EPC_o       = r_epc;
  assign Timer_Int_o = r_ti;
  assign Redirect_o  = w_flush;

  // Redirect target: vector on exception, pre-update EPC on ERET.
  always_comb begin
    Redirect_PC_o = 32'h0;
    if (Exc_Valid_i)
      Redirect_PC_o = EXC_VECTOR;
    else if (Exc_Eret_i)
      Redirect_PC_o = r_epc;
  end

  // MFC0 read mux; unimplemented addresses read zero.
  always_comb begin
    CP0_RdData_o = 32'h0;
    case (CP0_RdAddr_i)
      5'd8:    CP0_RdData_o = r_badvaddr;
      5'd9:    CP0_RdData_o = r_count;
      5'd11:   CP0_RdData_o = r_compare;
      5'd12:   CP0_RdData_o = w_status;
      5'd13:   CP0_RdData_o = w_cause;
      5'd14:   CP0_RdData_o = r_epc;
      default: CP0_RdData_o = 32'h0;
    endcase
  end

  // Count runs at half clock rate; a software load restarts the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= 32'h0;
      r_toggle <= 1'b0;
    end else if (w_wr_count) begin
      r_count  <= CP0_WrData_i;
      r_toggle <= 1'b0;
    end else begin
      r_toggle <= ~r_toggle;
      if (r_toggle)
        r_count <= r_count + 32'd1;
    end
  end

  // Compare register and sticky timer interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compare <= 32'h0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_compare) begin
        r_compare <= CP0_WrData_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti      <= 1'b1;
      end
    end
  end

  // Interrupt lines are sampled into Cause every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ext <= 6'h0;
    else
      r_ext <= Ext_Int_i;
  end

  // Exception entry, ERET and MTC0 to Status/Cause/EPC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im       <= 8'h0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_sw    <= 2'b0;
      r_exccode  <= 5'h0;
      r_epc      <= 32'h0;
      r_badvaddr <= 32'h0;
    end else if (Exc_Valid_i) begin
      r_exl     <= 1'b1;
      r_exccode <= Exc_Code_i;
      if (!r_exl) begin
        r_epc <= Exc_IsDelaySlot_i ? Exc_PC_i - 32'd4 : Exc_PC_i;
        r_bd  <= Exc_IsDelaySlot_i;
      end
      if (Exc_Code_i == 5'd4 || Exc_Code_i == 5'd5)
        r_badvaddr <= Exc_BadVAddr_i;
    end else if (Exc_Eret_i) begin
      r_exl <= 1'b0;
    end else if (w_wr) begin
      case (CP0_WrAddr_i)
        5'd12: begin
          r_im  <= CP0_WrData_i[15:8];
          r_exl <= CP0_WrData_i[1];
          r_ie  <= CP0_WrData_i[0];
        end
        5'd13:   r_ip_sw <= CP0_WrData_i[9:8];
        5'd14:   r_epc   <= CP0_WrData_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Randomized bench for cp0_regs against a cycle-level reference model.
// Directed sequences cover timer, exception nesting, ERET and MTC0 collisions.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  ext = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ev = 1'b0;
  logic [4:0]  code = '0;
  logic        er = 1'b0;
  logic        ds = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] bva = '0;
  logic [31:0] status, cause, epc;
  logic        ti, redir;
  logic [31:0] redir_pc;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  cp0_regs dut (
    .clk(clk), .rst(rst), .Ext_Int_i(ext),
    .CP0_RdAddr_i(rd_addr), .CP0_RdData_o(rd_data),
    .CP0_WrEn_i(wen), .CP0_WrAddr_i(waddr), .CP0_WrData_i(wdata),
    .Exc_Valid_i(ev), .Exc_Code_i(code), .Exc_Eret_i(er),
    .Exc_IsDelaySlot_i(ds), .Exc_PC_i(pc), .Exc_BadVAddr_i(bva),
    .Status_o(status), .Cause_o(cause), .EPC_o(epc),
    .Timer_Int_o(ti), .Redirect_o(redir), .Redirect_PC_o(redir_pc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference state. Count is base plus half the edges since load.
  logic [31:0] m_base, m_compare, m_epc, m_bad;
  int unsigned m_since;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_ext;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_since / 2);
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1)
         | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = (32'(m_bd) << 31) | (32'(m_ti) << 30);
    c = c | (32'(m_ext[5] | m_ti) << 15) | (32'(m_ext[4:0]) << 10);
    c = c | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
    return c;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_base = 0; m_since = 0; m_compare = 0; m_epc = 0; m_bad = 0;
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_ext = 0; m_ipsw = 0; m_exc = 0;
  endtask

  task automatic m_step();
    logic wr, nti;
    wr  = wen && !(ev || er);
    nti = m_ti || (m_count() == m_compare);
    if (wr && waddr == 5'd11) nti = 1'b0;
    if (wr && waddr == 5'd9) begin
      m_base = wdata; m_since = 0;
    end else begin
      m_since++;
    end
    if (wr && waddr == 5'd11) m_compare = wdata;
    m_ext = ext;
    if (ev) begin
      if (!m_exl) begin
        m_epc = ds ? pc - 4 : pc;
        m_bd  = ds;
      end
      m_exl = 1'b1;
      m_exc = code;
      if (code == 5'd4 || code == 5'd5) m_bad = bva;
    end else if (er) begin
      m_exl = 1'b0;
    end else if (wr) begin
      if (waddr == 5'd12) begin
        m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0];
      end
      if (waddr == 5'd13) m_ipsw = wdata[9:8];
      if (waddr == 5'd14) m_epc = wdata;
    end
    m_ti = nti;
  endtask

  // Called just after a falling edge with inputs set; ends at next one.
  task automatic tick();
    #1;
    chk("status", status, m_status());
    chk("cause", cause, m_cause());
    chk("epc", epc, m_epc);
    chk("ti", 32'(ti), 32'(m_ti));
    chk("redir", 32'(redir), 32'(ev | er));
    chk("redir_pc", redir_pc, ev ? VEC : (er ? m_epc : 32'h0));
    chk("rdata", rd_data, m_rd(rd_addr));
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ext = 0; wen = 0; ev = 0; er = 0; ds = 0;
    waddr = 0; wdata = 0; code = 0; pc = 0; bva = 0;
  endtask

  logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12,
                            5'd13, 5'd14, 5'd3, 5'd0};
  logic [4:0] codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8,
                            5'd9, 5'd10, 5'd12};

  initial begin
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_status", status, 32'h0040_0000);
    chk("rst_cause", cause, 32'h0);
    chk("rst_ti", 32'(ti), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Idle count after release.
    repeat (10) tick();
    rd_addr = 5'd3; #1 chk("rd_unimpl", rd_data, 32'h0);
    rd_addr = 5'd9; #1 chk("count10", rd_data, 32'd5);
    chk("status_idle", status, 32'h0040_0000);

    // Timer match at Compare=8.
    wen = 1; waddr = 5'd11; wdata = 32'd8; tick();
    waddr = 5'd9; wdata = 32'd0; tick();
    wen = 0; rd_addr = 5'd9;
    repeat (16) tick();
    #1 chk("count8", rd_data, 32'd8);
    chk("ti_pre", 32'(ti), 32'h0);
    tick();
    #1 chk("ti_set", 32'(ti), 32'h1);
    chk("ip7", 32'(cause[15]), 32'h1);
    chk("count8b", rd_data, 32'd8);
    wen = 1; waddr = 5'd11; wdata = 32'd20; tick();
    wen = 0;
    #1 chk("ti_clr", 32'(ti), 32'h0);

    // AdEL in a delay slot.
    ev = 1; code = 5'd4; pc = 32'h8000_0104; ds = 1; bva = 32'h1233;
    #1 chk("vec", redir_pc, VEC);
    tick();
    idle();
    rd_addr = 5'd8;
    #1 chk("epc_ds", epc, 32'h8000_0100);
    chk("bd", 32'(cause[31]), 32'h1);
    chk("exl", 32'(status[1]), 32'h1);
    chk("exccode4", 32'(cause[6:2]), 32'd4);
    chk("badva", rd_data, 32'h1233);

    // Nested syscall, then ERET.
    ev = 1; code = 5'd8; pc = 32'h8000_0200; tick();
    idle();
    #1 chk("epc_keep", epc, 32'h8000_0100);
    chk("exccode8", 32'(cause[6:2]), 32'd8);
    er = 1;
    #1 chk("eret_pc", redir_pc, 32'h8000_0100);
    tick();
    idle();
    #1 chk("exl_clr", 32'(status[1]), 32'h0);

    // MTC0 Status colliding with overflow.
    wen = 1; waddr = 5'd12; wdata = 32'h0000_FF01;
    ev = 1; code = 5'd12; pc = 32'h8000_0300;
    tick();
    idle();
    #1 chk("im_keep", 32'(status[15:8]), 32'h0);
    chk("exl_ov", 32'(status[1]), 32'h1);
    chk("ie_keep", 32'(status[0]), 32'h0);
    wen = 1; waddr = 5'd13; wdata = 32'hFFFF_FFFF; tick();
    idle();
    #1 chk("cause_wr", cause & ~32'h4000_FC00, 32'h0000_0330);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      ext     = 6'($urandom);
      rd_addr = ($urandom % 4 == 0) ? 5'($urandom) : addrs[$urandom % 8];
      wen     = 1'($urandom);
      waddr   = addrs[$urandom % 8];
      wdata   = ($urandom % 2) ? 32'($urandom_range(0, 40)) : $urandom;
      ev      = ($urandom % 8 == 0);
      er      = ($urandom % 8 == 0);
      code    = codes[$urandom % 7];
      ds      = 1'($urandom);
      pc      = $urandom & 32'hFFFF_FFFC;
      bva     = $urandom;
      tick();
    end

    // Mid-run asynchronous reset.
    idle();
    rd_addr = 5'd9;
    #2 rst = 1'b0;
    #1 chk("arst_count", rd_data, 32'h0);
    chk("arst_status", status, 32'h0040_0000);
    chk("arst_ti", 32'(ti), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 EXC_VECTOR, 32'hBFC0_0380, exception entry address driven on redirect.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 Ext_Int_i  in  6  hardware interrupt lines, level-sensitive, already synchronized.
REQ-005 CP0_RdAddr_i  in  5  MFC0 register number.
REQ-006 CP0_RdData_o  out  32  MFC0 read data.
REQ-007 CP0_WrEn_i / CP0_WrAddr_i / CP0_WrData_i  in  1/5/32  MTC0 write from WB stage.
REQ-008 Exc_Valid_i  in  1  MEM-stage instruction raised a final exception (not ERET).
REQ-009 Exc_Code_i  in  5  MIPS ExcCode for Exc_Valid_i (0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov).
REQ-010 Exc_Eret_i  in  1  MEM-stage instruction is ERET.
REQ-011 Exc_IsDelaySlot_i / Exc_PC_i / Exc_BadVAddr_i  in  1/32/32  delay-slot flag, PC, faulting address.
REQ-012 Status_o / Cause_o / EPC_o  out  32 each  current register values to the exception unit.
REQ-013 Timer_Int_o  out  1  Cause.TI.
REQ-014 Redirect_o / Redirect_PC_o  out  1/32  fetch redirect request and target.

Function
REQ-015 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); all other addresses read 0, writes ignored.
REQ-016 CP0_RdData_o combinational from register state; no WB bypass inside this block.
REQ-017 Status: bit22 BEV reads constant 1; IM[15:8], EXL[1], IE[0] writable; all other bits read 0.
REQ-018 Cause: BD[31], TI[30], IP[15:10], IP[9:8], ExcCode[6:2]; only IP[9:8] MTC0-writable.
REQ-019 Cause.IP[15:10] sampled every cycle: IP[15]=Ext_Int_i[5]|TI, IP[14:10]=Ext_Int_i[4:0].
REQ-020 Count increments by 1 every second cycle via internal toggle bit; wraps 32'hFFFF_FFFF -> 0 silently.
REQ-021 MTC0 to Count loads value, resets toggle; write wins over same-cycle increment.
REQ-022 TI set the cycle after Count == Compare (Compare != 0 not required); sticky until MTC0 Compare, which clears TI same edge.
REQ-023 Exception (Exc_Valid_i=1), when Status.EXL=0: EPC <= Exc_PC_i-4 if delay slot else Exc_PC_i; BD <= Exc_IsDelaySlot_i.
REQ-024 Exception when Status.EXL=1: EPC and BD unchanged; ExcCode still updated.
REQ-025 Every exception: EXL <= 1, ExcCode <= Exc_Code_i; BadVAddr <= Exc_BadVAddr_i only for codes 4/5.
REQ-026 ERET (Exc_Eret_i=1, Exc_Valid_i=0): EXL <= 0.
REQ-027 Exc_Valid_i and Exc_Eret_i both 1: exception path only.
REQ-028 Same-cycle exception/ERET and MTC0: MTC0 discarded (WB instruction belongs to flushed window); Count/TI hardware updates still occur.
REQ-029 Redirect_o combinational = Exc_Valid_i|Exc_Eret_i; Redirect_PC_o = EXC_VECTOR on exception, EPC_o (pre-update value) on ERET, else 0.
REQ-030 Latency: register updates visible on outputs one cycle after the triggering edge inputs.

Reset
REQ-031 rst low: asynchronously Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0; Redirect_o=0, Timer_Int_o=0.
REQ-032 Reset deassertion mid-operation: first increment of Count occurs on second rising edge after release.

Verification
REQ-033 Reset release, idle 10 cycles -> Count=5, Status=32'h0040_0000, CP0_RdData_o for addr 3 = 0.
REQ-034 MTC0 Compare=8, Count=0, run -> TI=1 and Cause[15]=1 at Count=8; MTC0 Compare=20 -> TI=0 next cycle.
REQ-035 Exc_Valid_i, code 4, PC=0x8000_0104, delay slot, BadVAddr=0x1233 -> Redirect_PC_o=0xBFC0_0380; next cycle EPC=0x8000_0100, BD=1, EXL=1, ExcCode=4, BadVAddr=0x1233.
REQ-036 Second exception (code 8) while EXL=1 -> EPC unchanged, ExcCode=8; then ERET -> Redirect_PC_o=EPC, EXL=0 next cycle.
REQ-037 Same cycle MTC0 Status=0xFF01 and exception code 12 -> Status IM unchanged, EXL=1; MTC0 to Cause=0xFFFF_FFFF -> only IP[9:8] set.
